// File: rtl/multiply_module.sv
// Sequential signed Q-format multiplier: radix-2 shift-add on operand
// magnitudes, one multiplier bit per cycle, then round-half-away-from-zero
// and saturate back to D_WIDTH bits.
module multiply_module #(
    parameter int Q_BITS  = 10,
    parameter int D_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] multiplicand,
    input  logic [D_WIDTH-1:0] multiplier,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [D_WIDTH-1:0] product,
    output logic               overflow,
    output logic               valid_out
);

    localparam int AW = 2 * D_WIDTH;
    localparam int CW = $clog2(D_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(D_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Rounding addend: half an LSB of the Q-format result
    localparam logic [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (Q_BITS - 1);
    // Largest positive magnitude and largest negative magnitude
    localparam logic [AW-1:0] POS_LIM = {{(D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] NEG_LIM = {{(D_WIDTH-1){1'b0}}, 1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [D_WIDTH-1:0] MAX_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [D_WIDTH-1:0] ONE_D   = {{(D_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       mcand_sh;   // multiplicand magnitude, shifted left each step
    logic [D_WIDTH-1:0]  mplier_sh;  // multiplier magnitude, shifted right each step
    logic [CW-1:0]       cnt;
    logic                sign;

    logic [D_WIDTH-1:0]  a_mag, b_mag;
    logic [AW-1:0]       rounded, mag;
    logic [D_WIDTH-1:0]  res_prod;
    logic                res_ovf;

    // Operand magnitudes; |-2^(D_WIDTH-1)| comes out as 2^(D_WIDTH-1) unsigned
    always_comb begin
        a_mag = multiplicand[D_WIDTH-1] ? (~multiplicand + ONE_D) : multiplicand;
        b_mag = multiplier[D_WIDTH-1]   ? (~multiplier + ONE_D)   : multiplier;
    end

    // Round the accumulated magnitude, then saturate into the signed range
    always_comb begin
        rounded  = acc + RND;
        mag      = rounded >> Q_BITS;
        res_prod = mag[D_WIDTH-1:0];
        res_ovf  = 1'b0;
        if (!sign) begin
            if (mag > POS_LIM) begin
                res_prod = MAX_POS;
                res_ovf  = 1'b1;
            end
        end else if (mag > NEG_LIM) begin
            res_prod = MIN_NEG;
            res_ovf  = 1'b1;
        end else begin
            // zero magnitude negates to +0, so no special case is needed
            res_prod = ~mag[D_WIDTH-1:0] + ONE_D;
        end
    end

    assign ready_out = (state == IDLE);

    // Control FSM and shift-add datapath with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            product   <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        mcand_sh  <= {{D_WIDTH{1'b0}}, a_mag};
                        mplier_sh <= b_mag;
                        sign      <= multiplicand[D_WIDTH-1] ^ multiplier[D_WIDTH-1];
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    if (mplier_sh[0]) acc <= acc + mcand_sh;
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                    cnt       <= cnt + CNT_ONE;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    product   <= res_prod;
                    overflow  <= res_ovf;
                    valid_out <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_module.sv
// Randomized scoreboard bench for multiply_module: a 64-bit arithmetic
// reference computes expected results at acceptance; a negedge monitor
// checks them (and their timing) whenever valid_out appears.
module tb_multiply_module;

    localparam int Q = 10;
    localparam int D = 32;
    localparam int LAT = D + 1;

    logic         clock = 1'b0;
    logic         reset;
    logic [D-1:0] multiplicand, multiplier;
    logic         valid_in;
    logic         ready_out;
    logic [D-1:0] product;
    logic         overflow;
    logic         valid_out;

    multiply_module #(.Q_BITS(Q), .D_WIDTH(D)) dut (
        .clock(clock), .reset(reset),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .valid_in(valid_in), .ready_out(ready_out),
        .product(product), .overflow(overflow), .valid_out(valid_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [D-1:0] p;
        logic         o;
        int           due;
    } exp_t;

    exp_t   q[$];
    int     cyc = 0;
    int     busy = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    logic [D-1:0] last_p = '0;
    logic         last_o = 1'b0;
    logic         prev_vo = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_ev(input string name, input int act, input int exp);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: exact signed product, round half away from zero, saturate
    function automatic exp_t ref_mul(input logic [D-1:0] a, input logic [D-1:0] b);
        exp_t   e;
        longint sa, sb, pr, m, lim;
        bit     neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        pr  = sa * sb;
        neg = (pr < 0);
        m   = neg ? -pr : pr;
        m   = (m + (longint'(1) <<< (Q - 1))) >>> Q;
        lim = (longint'(1) <<< (D - 1)) - 1;
        e.o = 1'b0;
        if (!neg) begin
            if (m > lim) begin e.p = D'(lim); e.o = 1'b1; end
            else e.p = D'(m);
        end else begin
            if (m > lim + 1) begin e.p = D'(-(lim + 1)); e.o = 1'b1; end
            else e.p = D'(-m);
        end
        e.due = 0;
        return e;
    endfunction

    // Acceptance model: idle when busy==0; an accepted op keeps it busy D+1 edges
    always @(posedge clock) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            q.delete();
            busy = 0;
        end else if (busy == 0 && valid_in) begin
            e = ref_mul(multiplicand, multiplier);
            e.due = cyc + LAT;
            q.push_back(e);
            busy = LAT;
        end else if (busy > 0) begin
            busy--;
        end
    end

    // Monitor: pops the scoreboard on valid_out, checks hold/latency otherwise
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            last_p  = '0;
            last_o  = 1'b0;
            prev_vo = 1'b0;
        end else begin
            chk("ready_out", 64'(ready_out), 64'(busy == 0));
            if (valid_out) begin
                if (prev_vo) fail_ev("valid_out_width", 2, 1);
                if (q.size() == 0) begin
                    fail_ev("unexpected_valid_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("product", 64'(product), 64'(e.p));
                    chk("overflow", 64'(overflow), 64'(e.o));
                    chk("latency_cycle", 64'(cyc), 64'(e.due));
                    last_p = e.p;
                    last_o = e.o;
                end
            end else begin
                chk("product_hold", 64'(product), 64'(last_p));
                chk("overflow_hold", 64'(overflow), 64'(last_o));
                if (q.size() != 0 && cyc > q[0].due) begin
                    e = q.pop_front();
                    fail_ev("missing_valid_out", cyc, e.due);
                end
            end
            prev_vo = valid_out;
        end
    end

    function automatic logic [D-1:0] rnd_op();
        logic [D-1:0] v;
        logic [D-1:0] pick [5];
        pick[0] = 32'h8000_0000; pick[1] = 32'h7FFF_FFFF; pick[2] = '0;
        pick[3] = 32'h0000_0001; pick[4] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = D'($urandom_range(0, 1 << 20));
            2: v = pick[$urandom_range(0, 4)];
            default: v = D'($urandom_range(0, 1 << 15));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // All stimulus changes happen 2 time units after a rising edge
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy != 0 && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        if (busy != 0) fail_ev("wait_idle_timeout", n, 100);
    endtask

    task automatic run_op(input logic [D-1:0] a, input logic [D-1:0] b);
        wait_idle();
        multiplicand = a;
        multiplier   = b;
        valid_in     = 1'b1;
        @(posedge clock); #2;
        valid_in     = 1'b0;
        multiplicand = $urandom;   // operands may change after acceptance
        multiplier   = $urandom;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        valid_in = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_product", 64'(product), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_ready_out", 64'(ready_out), 64'd1);
        reset = 1'b1;
        @(posedge clock); #2;

        // Directed cases: sign handling, rounding, saturation boundaries
        run_op(32'd1536, 32'd2048);
        run_op(-32'sd1536, 32'd2048);
        run_op(-32'sd1536, -32'sd2048);
        run_op(32'd0, -32'sd5);
        run_op(32'd512, 32'd1);
        run_op(-32'sd512, 32'd1);
        run_op(32'd511, 32'd1);
        run_op(32'd1, 32'd1);
        run_op(32'h7FFF_FFFF, 32'd2048);
        run_op(32'h8000_0000, 32'd1024);
        run_op(32'h8000_0000, 32'd2048);
        run_op(32'h7FFF_FFFF, 32'd1024);

        // Random operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            run_op(rnd_op(), rnd_op());
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock); #2;
            end
        end

        // valid_in held high, operands changing every cycle
        wait_idle();
        valid_in = 1'b1;
        for (int i = 0; i < 150; i++) begin
            multiplicand = rnd_op();
            multiplier   = rnd_op();
            @(posedge clock); #2;
        end
        valid_in = 1'b0;

        // Reset pulse 10 cycles into MUL aborts the operation
        run_op(32'd3000, 32'd7000);
        repeat (9) begin
            @(posedge clock); #2;
        end
        reset = 1'b0;
        #1;
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        chk("abort_valid_out", 64'(valid_out), 64'd0);
        chk("abort_ready_out", 64'(ready_out), 64'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #2;
        run_op(32'd1536, 32'd2048);

        // Drain the scoreboard
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clock); #2;
            n++;
        end
        if (q.size() != 0) fail_ev("drain_timeout", q.size(), 0);
        repeat (3) @(posedge clock);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multiply_module.md
# multiply_module

Sequential signed fixed-point multiplier, the counterpart of the team's shift-subtract divider. It computes `product = multiplicand * multiplier` in the same Q-format (Q_BITS fractional bits, D_WIDTH total) and uses the same valid_in/valid_out handshake, plus a ready_out back-pressure signal. It sits in the ray-tracer arithmetic path beside the divider, in dot/cross-product and scaling stages. It uses a radix-2 shift-add datapath on operand magnitudes, with rounding and saturation on output.

## Interface
- Q_BITS, 10, number of fractional bits in all operands and the result; legal range 1..D_WIDTH-1
- D_WIDTH, 32, data width of operands and result (two's complement)
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- multiplicand  in  D_WIDTH  signed Q-format operand A
- multiplier  in  D_WIDTH  signed Q-format operand B
- valid_in  in  1  operands valid; accepted only when ready_out=1
- ready_out  out  1  block idle and able to accept an operation; equals (state==IDLE)
- product  out  D_WIDTH  signed Q-format result, registered; holds last result
- overflow  out  1  registered; set with a result that saturated
- valid_out  out  1  registered one-cycle pulse marking a new product/overflow

## Operation
- States: IDLE, MUL, DONE.
- IDLE:
  - ready_out=1.
  - On valid_in=1, capture |multiplicand| and |multiplier| as D_WIDTH-bit unsigned magnitudes. |-2^(D_WIDTH-1)| = 2^(D_WIDTH-1) fits.
  - Capture sign = XOR of the operand sign bits.
  - Clear the 2*D_WIDTH-bit unsigned accumulator and the bit counter. Go to MUL.
  - valid_in while not in IDLE is ignored. Operands are sampled only at acceptance and may change afterwards.
- MUL, one bit per cycle, LSB first:
  - If the current multiplier-magnitude bit is 1, add (multiplicand magnitude << counter) to the accumulator.
  - Increment the counter.
  - After D_WIDTH iterations, go to DONE.
- DONE:
  - mag = (acc + 2^(Q_BITS-1)) >> Q_BITS. This rounds half away from zero, symmetric for both signs.
  - sign=0: if mag > 2^(D_WIDTH-1)-1, product = 2^(D_WIDTH-1)-1 and overflow=1; otherwise product = mag.
  - sign=1: if mag > 2^(D_WIDTH-1), product = -2^(D_WIDTH-1) and overflow=1; otherwise product = -mag.
  - A zero-magnitude result is +0 regardless of sign.
  - Register product and overflow, pulse valid_out, return to IDLE.
- Width rules: the raw magnitude product is at most 2^(2*D_WIDTH-2), and the rounding addend never carries beyond bit 2*D_WIDTH-1, so no internal wrap is possible.

## Timing
- Reset value of every output: product=0, overflow=0, valid_out=0. State is IDLE, so ready_out=1.
- Reset asserted in any state aborts the operation immediately. No valid_out follows, and the accumulator and counter clear.
- Acceptance: valid_in=1 and ready_out=1 at rising edge k.
- MUL occupies cycles k+1..k+D_WIDTH.
- DONE registers the result at edge k+D_WIDTH+1. valid_out is high for exactly that one cycle; product/overflow update at the same edge.
- Latency is D_WIDTH+1 edges from acceptance to valid_out (33 for default D_WIDTH).
- ready_out is high again in the valid_out cycle. Earliest next acceptance is edge k+D_WIDTH+2, giving a throughput of one operation per D_WIDTH+2 cycles (34 for default D_WIDTH).
- product and overflow hold their values until the next DONE. valid_out is never asserted for more than one consecutive cycle.

## Test plan
All values use Q_BITS=10, D_WIDTH=32.
- 1536 (1.5) × 2048 (2.0) -> product=3072, overflow=0, valid_out exactly 33 edges after acceptance, one cycle wide.
- -1536 × 2048 -> -3072; -1536 × -2048 -> 3072; 0 × -5 -> 0.
- Rounding:
  - 512 × 1 -> 1.
  - -512 × 1 -> -1.
  - 511 × 1 -> 0.
  - 1 × 1 -> 0.
- Saturation boundaries:
  - 0x7FFFFFFF × 2048 -> 0x7FFFFFFF, overflow=1.
  - -2^31 × 1024 -> -2^31, overflow=0.
  - -2^31 × 2048 -> -2^31, overflow=1.
  - 2^31-1 × 1024 -> 2^31-1, overflow=0.
- valid_in held high with operands changing every cycle:
  - Only operands present at ready_out=1 edges are used.
  - Results are spaced 34 cycles apart.
  - Operand changes during MUL do not affect the result.
- reset driven low for one cycle, 10 cycles into MUL:
  - No valid_out.
  - product=0, overflow=0, ready_out=1.
  - The next operation completes correctly with the standard 33-edge latency.
